pdm_multi: RTL and testbench

Parametrised multi-channel pulse-density modulator, the successor to the single 5-bit first-order PDM core in the user-module pin mux. It holds `CHANNELS` independent `WIDTH`-bit duty values with double-buffered (shadow/active) registers, and commits them all at once on a single strobe. Each channel is modulated by a runtime-selectable first- or second-order sigma-delta loop. Outputs drive GPIO directly, one bit per channel.

---
 rtl/pdm_pkg.sv | 26 ++
 rtl/pdm_channel.sv | 64 ++++++
 rtl/pdm_multi.sv | 63 ++++++
 tb/tb_pdm_multi.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared constants and arithmetic helpers for the multi-channel PDM.
// Integrator math is done in plain int so every legal WIDTH (2..12) fits with headroom.
package pdm_pkg;

  localparam logic MODE_FIRST  = 1'b0;
  localparam logic MODE_SECOND = 1'b1;

  // Second-order integrator width: four guard bits over the duty value.
  function automatic int int_w(input int w);
    return w + 4;
  endfunction

  // Signed add clamped to an iw-bit two's-complement range; never wraps.
  function automatic int sat_add(input int a, input int b, input int iw);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (iw - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/pdm_channel.sv
// One modulator channel: first-order accumulator, second-order integrator pair,
// and the registered output bit. The active duty value is supplied by the top level.
module pdm_channel
  import pdm_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             clear,
  input  logic             mode_q,
  input  logic             enable,
  input  logic [WIDTH-1:0] active,
  output logic             pdm_out
);

  localparam int IW = int_w(WIDTH);

  logic [WIDTH-1:0]     acc_q, acc_d;
  logic signed [IW-1:0] i1_q, i1_d;
  logic signed [IW-1:0] i2_q, i2_d;
  logic                 pdm_q, pdm_d;
  logic [WIDTH:0]       sum;
  int                   fb;

  always_comb begin
    acc_d = acc_q;
    i1_d  = i1_q;
    i2_d  = i2_q;
    pdm_d = pdm_q;
    sum   = {1'b0, acc_q} + {1'b0, active};
    fb    = pdm_q ? (1 << WIDTH) : 0;
    if (clear || !enable) begin
      acc_d = '0;
      i1_d  = '0;
      i2_d  = '0;
      pdm_d = 1'b0;
    end else if (mode_q == MODE_FIRST) begin
      pdm_d = sum[WIDTH];
      acc_d = sum[WIDTH-1:0];
    end else begin
      i1_d  = IW'(sat_add(int'(i1_q), int'({1'b0, active}) - fb, IW));
      i2_d  = IW'(sat_add(int'(i2_q), int'(i1_d) - fb, IW));
      pdm_d = !i2_d[IW-1] && (i2_d != '0);
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      acc_q <= '0;
      i1_q  <= '0;
      i2_q  <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_out = pdm_q;

endmodule

// File: rtl/pdm_multi.sv
// Multi-channel pulse-density modulator with shadow/active duty registers,
// a global commit strobe and runtime first/second-order selection.
module pdm_multi
  import pdm_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 2
) (
  input  logic                                        Clock,
  input  logic                                        nReset,
  input  logic                                        enable,
  input  logic                                        mode,
  input  logic                                        wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_addr,
  input  logic [WIDTH-1:0]                            wr_data,
  input  logic                                        commit,
  output logic [CHANNELS-1:0]                         pdm_out
);

  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0][WIDTH-1:0] active_q, active_d;
  logic                           mode_q, mode_d;
  logic                           mode_chg;
  logic                           wr_hit;

  assign wr_hit   = wr_en && (32'(wr_addr) < CHANNELS);
  assign mode_chg = (mode != mode_q);

  // Commit copies the post-write shadow, which gives write-through for free.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_hit) shadow_d[wr_addr] = wr_data;
    active_d = commit ? shadow_d : active_q;
    mode_d   = mode;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      shadow_q <= '0;
      active_q <= '0;
      mode_q   <= MODE_FIRST;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      mode_q   <= mode_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pdm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .Clock  (Clock),
      .nReset (nReset),
      .clear  (mode_chg),
      .mode_q (mode_q),
      .enable (enable),
      .active (active_q[g]),
      .pdm_out(pdm_out[g])
    );
  end

endmodule

// File: tb/tb_pdm_multi.sv
// Scoreboard bench for pdm_multi (W=5, C=3): a behavioural model pushes expected
// output vectors at stimulus time; a monitor pops and compares after each edge.
module tb_pdm_multi;

  localparam int W  = 5;
  localparam int C  = 3;
  localparam int AW = 2;
  localparam int IW = W + 4;

  logic          Clock = 1'b0;
  logic          nReset, enable, mode, wr_en, commit;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [C-1:0]  pdm_out;

  pdm_multi #(.WIDTH(W), .CHANNELS(C)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .enable (enable),
    .mode   (mode),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit (commit),
    .pdm_out(pdm_out)
  );

  always #5 Clock = ~Clock;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [C-1:0] exp_q[$];
  logic [C-1:0] smp;
  int           cnt[C];
  logic         cur_mode;

  int m_sh[C], m_act[C], m_acc[C], m_i1[C], m_i2[C], m_out[C];
  int m_mode;

  function automatic int clamp(input int v);
    int hi;
    hi = (1 << (IW - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  // Reference: spec equations on plain ints, evaluated for the coming edge.
  task automatic model_step();
    logic [C-1:0] e;
    int s, fb;
    if (!nReset) begin
      for (int c = 0; c < C; c++) begin
        m_sh[c] = 0; m_act[c] = 0; m_acc[c] = 0;
        m_i1[c] = 0; m_i2[c] = 0; m_out[c] = 0;
      end
      m_mode = 0;
    end else begin
      for (int c = 0; c < C; c++) begin
        if (int'(mode) != m_mode || !enable) begin
          m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_out[c] = 0;
        end else if (m_mode == 0) begin
          s        = m_acc[c] + m_act[c];
          m_out[c] = (s >= 2 ** W) ? 1 : 0;
          m_acc[c] = s % (2 ** W);
        end else begin
          fb       = m_out[c] ? 2 ** W : 0;
          m_i1[c]  = clamp(m_i1[c] + m_act[c] - fb);
          m_i2[c]  = clamp(m_i2[c] + m_i1[c] - fb);
          m_out[c] = (m_i2[c] > 0) ? 1 : 0;
        end
      end
      m_mode = int'(mode);
      if (wr_en && int'(wr_addr) < C) m_sh[wr_addr] = int'(wr_data);
      if (commit) for (int c = 0; c < C; c++) m_act[c] = m_sh[c];
    end
    for (int c = 0; c < C; c++) e[c] = (m_out[c] != 0);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rn, input logic en, input logic md, input logic we,
                       input int addr, input int data, input logic cm);
    @(negedge Clock);
    smp     = pdm_out;
    nReset  = rn;
    enable  = en;
    mode    = md;
    wr_en   = we;
    wr_addr = addr[AW-1:0];
    wr_data = data[W-1:0];
    commit  = cm;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1, cur_mode, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic count(input int n);
    for (int c = 0; c < C; c++) cnt[c] = 0;
    repeat (n) begin
      idle(1);
      for (int c = 0; c < C; c++) cnt[c] += int'(smp[c]);
    end
  endtask

  task automatic check(input string nm, input int got, input int lo, input int hi);
    n_chk++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", nm, got, lo, hi);
    end
  endtask

  initial begin
    logic [C-1:0] e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (pdm_out !== e) begin
          n_fail++;
          $display("FAIL pdm_out @%0t: got %b, required %b", $time, pdm_out, e);
        end
      end
    end
  end

  initial begin
    logic [3:0] pat;
    nReset = 1'b0; enable = 1'b0; mode = 1'b0; wr_en = 1'b0;
    commit = 1'b0; wr_addr = '0; wr_data = '0; cur_mode = 1'b0;

    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 16, 1'b1);
    idle(10);

    // Reset mid-stream must clear outputs without waiting for an edge.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    #1;
    check("rst_immediate", int'(pdm_out), 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 16, 1'b1);
    idle(1);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      pat[k] = smp[0];
    end
    check("half_pattern", int'(pat), 4'b1010, 4'b1010);

    // Double buffer.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1, 8, 1'b0);
    count(32);
    check("ch1_no_commit", cnt[1], 0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    idle(2);
    count(32);
    check("ch1_commit8", cnt[1], 8, 8);
    check("ch0_16", cnt[0], 16, 16);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 31, 1'b1);
    idle(2);
    count(32);
    check("ch0_wt31", cnt[0], 31, 31);
    check("ch1_kept8", cnt[1], 8, 8);

    // Out-of-range address is ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3, 31, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    idle(2);
    count(32);
    check("oor_ch2", cnt[2], 0, 0);
    check("oor_ch1", cnt[1], 8, 8);
    check("oor_ch0", cnt[0], 31, 31);

    // Second order extremes.
    cur_mode = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 0, 31, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 1'b1);
    check("switch_clear", int'(smp), 0, 0);
    idle(64);
    count(128);
    check("so_ch0_31", cnt[0], 122, 126);
    check("so_ch1_0", cnt[1], 0, 0);

    // Switch back mid-stream.
    cur_mode = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(1);
    check("switch_back_clear", int'(smp), 0, 0);
    idle(40);

    repeat (10000) begin
      if ($urandom % 64 == 0) cur_mode = ~cur_mode;
      drive(($urandom % 3000) != 0, ($urandom % 16) != 0, cur_mode, $urandom % 2,
            int'($urandom % 4), int'($urandom % 32), ($urandom % 8) == 0);
    end
    idle(3);
    @(posedge Clock);
    #2;
    check("queue_drained", exp_q.size(), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
